// File: rtl/online_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : online_pkg
//  Description : Shared definitions for the on-line arithmetic stages:
//                signed-digit encodings and the two-state word FSM type.
//  Revision    : 1.0 - initial release
// ============================================================================
package online_pkg;

   // Signed-digit encoding {plus, minus}
   localparam logic [1:0] SD_POS  = 2'b10;
   localparam logic [1:0] SD_NEG  = 2'b01;
   localparam logic [1:0] SD_ZERO = 2'b00;
   localparam logic [1:0] SD_ILL  = 2'b11;

   // Word-level FSM shared by the on-line stages
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } online_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_digit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sd_digit_decode
//  Description : Combinational decode of a 2-bit signed digit into +1 / -1
//                flags plus an illegal-code flag. Code 11 decodes as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_digit_decode
   import online_pkg::*;
(
   input  logic [1:0] digit,
   output logic       is_pos,
   output logic       is_neg,
   output logic       illegal
);

   // Exact-match decode keeps 11 out of both the +1 and -1 paths
   always_comb begin
      is_pos  = (digit == SD_POS);
      is_neg  = (digit == SD_NEG);
      illegal = (digit == SD_ILL);
   end

endmodule
`default_nettype wire

// File: rtl/online_otf_converter.sv
`default_nettype none
// ============================================================================
//  Module      : online_otf_converter
//  Description : On-the-fly converter for an MSD-first signed-digit stream.
//                Keeps the Q / QM (= Q-1) register pair so the final
//                two's-complement value is available without a carry-
//                propagate add. Produces an (N+1)-bit result per N digits.
//  Options     : OTF_ILLEGAL_CHK_EN - build the sticky illegal-digit flag
//                driving err; otherwise err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module online_otf_converter
   import online_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   digit_in,
   input  logic         valid_in,
   input  logic         start,
   output logic [N:0]   result,
   output logic         result_valid,
   output logic         busy,
   output logic         err
);

   localparam int            CW     = $clog2(N + 1);
   localparam logic [CW-1:0] C_LAST = CW'(N);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   online_state_t state;
   online_state_t state_nx;

   logic [N:0]    q;
   logic [N:0]    qm;
   logic [CW-1:0] count;

   logic          is_pos;
   logic          is_neg;
   logic          digit_ill;

   logic          load;
   logic          accept;
   logic          complete;
   logic [N:0]    base_q;
   logic [N:0]    base_qm;
   logic [N:0]    q_nx;
   logic [N:0]    qm_nx;
   logic [CW-1:0] count_nx;

   sd_digit_decode u_decode (
      .digit   (digit_in),
      .is_pos  (is_pos),
      .is_neg  (is_neg),
      .illegal (digit_ill)
   );

   // Digit acceptance and Q/QM next values; a start digit converts from the reset pair
   always_comb begin
      load     = valid_in & start;
      accept   = valid_in & (start | (state == ACC));
      base_q   = load ? '0 : q;
      base_qm  = load ? '1 : qm;
      count_nx = load ? C_ONE : count + C_ONE;
      complete = accept & (count_nx == C_LAST);
      if (is_pos) begin
         q_nx  = {base_q[N-1:0], 1'b1};
         qm_nx = {base_q[N-1:0], 1'b0};
      end else if (is_neg) begin
         q_nx  = {base_qm[N-1:0], 1'b1};
         qm_nx = {base_qm[N-1:0], 1'b0};
      end else begin
         q_nx  = {base_q[N-1:0], 1'b0};
         qm_nx = {base_qm[N-1:0], 1'b1};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM next state: completion returns to IDLE, any other accepted digit lands in ACC
   always_comb begin
      state_nx = state;
      if (complete)    state_nx = IDLE;
      else if (accept) state_nx = ACC;
   end

   // FSM outputs
   always_comb begin
      busy = (state == ACC);
   end

   // Q/QM datapath, digit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q            <= '0;
         qm           <= '1;
         count        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= complete;
         if (accept) begin
            q     <= q_nx;
            qm    <= qm_nx;
            count <= complete ? '0 : count_nx;
         end
         if (complete) result <= q_nx;
      end
   end

`ifdef OTF_ILLEGAL_CHK_EN
   logic ill_flag;
   logic ill_nx;

   // Sticky per-word flag; a start digit begins a fresh word
   always_comb begin
      ill_nx = (load ? 1'b0 : ill_flag) | (accept & digit_ill);
   end

   // err is captured alongside result and holds with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_flag <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (accept)   ill_flag <= ill_nx;
         if (complete) err      <= ill_nx;
      end
   end
`else
   logic ill_unused;

   // No checking logic in this build
   always_comb begin
      ill_unused = digit_ill;
      err        = 1'b0;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_online_otf_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_online_otf_converter
//  Description : Directed self-checking bench for online_otf_converter (N=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_online_otf_converter;

   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] M = 2'b01;
   localparam logic [1:0] X = 2'b11;

   logic       clk;
   logic       rst_n;
   logic [1:0] digit_in;
   logic       valid_in;
   logic       start;
   logic [8:0] result;
   logic       result_valid;
   logic       busy;
   logic       err;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   online_otf_converter #(.N(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .digit_in     (digit_in),
      .valid_in     (valid_in),
      .start        (start),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count result_valid pulses away from the active edge
   always @(negedge clk) if (result_valid) pulses++;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] d, input logic st);
      @(negedge clk);
      digit_in = d;
      start    = st;
      valid_in = 1'b1;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      valid_in = 1'b0;
      start    = 1'b0;
      digit_in = 2'b00;
      repeat (n) @(posedge clk);
   endtask

   // Word of 8 digits, MSD at [15:14]; gap stall cycles between digits
   task automatic run_word(input string tag, input logic [15:0] digs, input int gap,
                           input logic [8:0] exp);
      int p0;
      p0 = pulses;
      for (int i = 0; i < 8; i++) begin
         send(digs[15-2*i -: 2], (i == 0));
         if (i < 7 && gap > 0) idle(gap);
      end
      #1;
      check({tag, "_rv"}, {31'd0, result_valid}, 32'd1);
      check({tag, "_res"}, {23'd0, result}, {23'd0, exp});
      idle(1);
      #1;
      check({tag, "_rv_drop"}, {31'd0, result_valid}, 32'd0);
      check({tag, "_pulses"}, pulses - p0, 32'd1);
   endtask

   initial begin
      int p0;
      rst_n    = 1'b0;
      valid_in = 1'b0;
      start    = 1'b0;
      digit_in = 2'b00;

      // Reset with random inputs toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         digit_in = 2'($urandom_range(0, 3));
         valid_in = 1'($urandom_range(0, 1));
         start    = 1'($urandom_range(0, 1));
         #1;
         check("rst_res", {23'd0, result}, 32'h000);
         check("rst_rv", {31'd0, result_valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_err", {31'd0, err}, 32'd0);
      end
      @(negedge clk);
      valid_in = 1'b0;
      start    = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(posedge clk);

      // valid without start in IDLE is ignored
      p0 = pulses;
      for (int i = 0; i < 9; i++) send(P, 1'b0);
      idle(2);
      #1;
      check("idle_nostart_busy", {31'd0, busy}, 32'd0);
      check("idle_nostart_pulses", pulses - p0, 32'd0);

      run_word("all_pos", 16'hAAAA, 0, 9'h0FF);
      run_word("pos_then_neg", 16'h9555, 0, 9'h001);
      run_word("all_neg", 16'h5555, 0, 9'h101);
      run_word("mixed", 16'h2402, 0, 9'h021);
      run_word("stall", 16'hAAAA, 3, 9'h0FF);

      // Busy during a partial word, result holds previous value
      send(P, 1'b1);
      #1;
      check("busy_acc", {31'd0, busy}, 32'd1);
      check("hold_res", {23'd0, result}, 32'h0FF);
      send(P, 1'b0);
      send(P, 1'b0);
      send(P, 1'b0);
      // Restart at digit 5
      run_word("restart", 16'h5555, 0, 9'h101);

      // Back-to-back words with zero bubble
      for (int i = 0; i < 8; i++) send(P, (i == 0));
      #1;
      check("b2b_rv1", {31'd0, result_valid}, 32'd1);
      check("b2b_res1", {23'd0, result}, 32'h0FF);
      for (int i = 0; i < 8; i++) begin
         send(M, (i == 0));
         if (i == 0) begin
            #1;
            check("b2b_rv_one_cycle", {31'd0, result_valid}, 32'd0);
            check("b2b_busy", {31'd0, busy}, 32'd1);
         end
      end
      #1;
      check("b2b_rv2", {31'd0, result_valid}, 32'd1);
      check("b2b_res2", {23'd0, result}, 32'h101);
      idle(1);

      // Illegal digit 3, converted as zero
      run_word("illegal", 16'hAEAA, 0, 9'h0DF);
`ifdef OTF_ILLEGAL_CHK_EN
      check("illegal_err", {31'd0, err}, 32'd1);
      idle(2);
      #1;
      check("illegal_err_hold", {31'd0, err}, 32'd1);
      run_word("clean", 16'hAAAA, 0, 9'h0FF);
      check("clean_err", {31'd0, err}, 32'd0);
`else
      check("illegal_err_off", {31'd0, err}, 32'd0);
`endif

      // Async reset in the middle of digit 4
      p0 = pulses;
      send(P, 1'b1);
      send(P, 1'b0);
      send(P, 1'b0);
      @(negedge clk);
      digit_in = P;
      valid_in = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_res", {23'd0, result}, 32'h000);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_rv", {31'd0, result_valid}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b1;
      idle(10);
      #1;
      check("midrst_pulses", pulses - p0, 32'd0);
      check("midrst_res_hold", {23'd0, result}, 32'h000);

      // Word after reset still converts
      run_word("post_rst", 16'h9555, 0, 9'h001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
